// File: rtl/riscv_pkg.sv
// Shared definitions for the execute-side pipeline: ALU opcodes,
// forwarding-source select and the ID/EX register layout.
package riscv_pkg;

  // Default datapath geometry; the ID/EX struct below is sized from these.
  localparam int XLEN   = 32;
  localparam int OP_W   = 4;
  localparam int RADDR_W = 5;

  // ALU operation codes as consumed by the downstream ALU.
  localparam logic [OP_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [OP_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [OP_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'b0011;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [OP_W-1:0] ALU_SLL  = 4'b0111;
  localparam logic [OP_W-1:0] ALU_SRL  = 4'b1000;
  localparam logic [OP_W-1:0] ALU_SLT  = 4'b1001;
  localparam logic [OP_W-1:0] ALU_SLTU = 4'b1010;
  localparam logic [OP_W-1:0] ALU_SRA  = 4'b1011;
  localparam logic [OP_W-1:0] ALU_BGE  = 4'b1100;
  localparam logic [OP_W-1:0] ALU_BGEU = 4'b1101;

  // Where an EX operand comes from.
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EXM = 2'd1,
    FWD_MWB = 2'd2
  } fwd_sel_t;

  // Contents of the ID/EX pipeline register.
  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [XLEN-1:0]    imm;
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rs2;
    logic [RADDR_W-1:0] rd;
    logic [OP_W-1:0]    alu_op;
    logic               alusrc;
    logic               asrc_pc;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
  } id_ex_t;

  // A bubble: no valid instruction, no side effects, neutral opcode.
  function automatic id_ex_t bubble();
    id_ex_t b;
    b        = '0;
    b.alu_op = ALU_AND;
    return b;
  endfunction

endpackage

// File: rtl/ex_forward_unit.sv
// Operand forwarding for one EX source register: picks the youngest
// in-flight producer (EX/MEM before MEM/WB), else the register-file value.
module ex_forward_unit
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [DATA_WIDTH-1:0] rf_data,
  input  logic                  exm_reg_write,
  input  logic [REG_ADDR_W-1:0] exm_rd,
  input  logic [DATA_WIDTH-1:0] exm_result,
  input  logic                  mwb_reg_write,
  input  logic [REG_ADDR_W-1:0] mwb_rd,
  input  logic [DATA_WIDTH-1:0] mwb_result,
  output fwd_sel_t              sel,
  output logic [DATA_WIDTH-1:0] value
);

  // Source selection; x0 is hardwired and never takes a forwarded value.
  always_comb begin
    sel = FWD_RF;
    if (rs != '0) begin
      if (exm_reg_write && (exm_rd == rs)) begin
        sel = FWD_EXM;
      end else if (mwb_reg_write && (mwb_rd == rs)) begin
        sel = FWD_MWB;
      end
    end
  end

  // Operand mux driven by the chosen source.
  always_comb begin
    value = rf_data;
    case (sel)
      FWD_EXM: value = exm_result;
      FWD_MWB: value = mwb_result;
      default: value = rf_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding, operand selection and
// load-use hazard detection, feeding the ALU directly.
module id_ex_stage
  import riscv_pkg::*;
#(
  // The ID/EX struct is sized from the package constants, so these must
  // stay equal to XLEN / OP_W / RADDR_W.
  parameter int DATA_WIDTH    = XLEN,
  parameter int OPCODE_LENGTH = OP_W,
  parameter int REG_ADDR_W    = RADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [DATA_WIDTH-1:0]    id_pc,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic [REG_ADDR_W-1:0]    id_rs1,
  input  logic [REG_ADDR_W-1:0]    id_rs2,
  input  logic [REG_ADDR_W-1:0]    id_rd,
  input  logic [OPCODE_LENGTH-1:0] id_alu_op,
  input  logic                     id_alusrc,
  input  logic                     id_asrc_pc,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     id_mem_write,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     exm_reg_write,
  input  logic [REG_ADDR_W-1:0]    exm_rd,
  input  logic [DATA_WIDTH-1:0]    exm_result,
  input  logic                     mwb_reg_write,
  input  logic [REG_ADDR_W-1:0]    mwb_rd,
  input  logic [DATA_WIDTH-1:0]    mwb_result,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic [DATA_WIDTH-1:0]    ex_pc,
  output logic [REG_ADDR_W-1:0]    ex_rd,
  output logic                     ex_valid,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic                     load_use_stall
);

  id_ex_t ex_reg;
  id_ex_t ex_next;
  id_ex_t id_fields;

  logic [REG_ADDR_W-1:0] src_idx  [2];
  logic [DATA_WIDTH-1:0] src_data [2];
  logic [DATA_WIDTH-1:0] fwd_val  [2];
  fwd_sel_t              fwd_sel  [2];
  logic                  unused_fwd_sel;

  // Pack the incoming ID fields into the register layout.
  always_comb begin
    id_fields           = '0;
    id_fields.valid     = id_valid;
    id_fields.pc        = id_pc;
    id_fields.rs1_data  = id_rs1_data;
    id_fields.rs2_data  = id_rs2_data;
    id_fields.imm       = id_imm;
    id_fields.rs1       = id_rs1;
    id_fields.rs2       = id_rs2;
    id_fields.rd        = id_rd;
    id_fields.alu_op    = id_alu_op;
    id_fields.alusrc    = id_alusrc;
    id_fields.asrc_pc   = id_asrc_pc;
    id_fields.reg_write = id_reg_write;
    id_fields.mem_read  = id_mem_read;
    id_fields.mem_write = id_mem_write;
  end

  // A load in EX whose destination ID is about to read cannot be forwarded in time.
  assign load_use_stall = ex_reg.valid & ex_reg.mem_read & (ex_reg.rd != '0) &
                          ((ex_reg.rd == id_rs1) | (ex_reg.rd == id_rs2)) & id_valid;

  // Next-state selection: flush beats stall beats hazard bubble beats capture.
  always_comb begin
    ex_next = ex_reg;
    if (flush) begin
      ex_next = bubble();
    end else if (stall) begin
      ex_next = ex_reg;
    end else if (load_use_stall) begin
      ex_next = bubble();
    end else begin
      ex_next = id_fields;
    end
  end

  // ID/EX register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_reg <= '0;
    end else begin
      ex_reg <= ex_next;
    end
  end

  assign src_idx[0]  = ex_reg.rs1;
  assign src_idx[1]  = ex_reg.rs2;
  assign src_data[0] = ex_reg.rs1_data;
  assign src_data[1] = ex_reg.rs2_data;

  // One forwarding unit per source operand; they re-evaluate every cycle,
  // including while EX is frozen.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      ex_forward_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_ADDR_W (REG_ADDR_W)
      ) u_fwd (
        .rs            (src_idx[gi]),
        .rf_data       (src_data[gi]),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .mwb_reg_write (mwb_reg_write),
        .mwb_rd        (mwb_rd),
        .mwb_result    (mwb_result),
        .sel           (fwd_sel[gi]),
        .value         (fwd_val[gi])
      );
    end
  endgenerate

  // Select codes are only observed through the forwarded values here.
  assign unused_fwd_sel = ^{fwd_sel[0], fwd_sel[1]};

  assign SrcA          = ex_reg.asrc_pc ? ex_reg.pc  : fwd_val[0];
  assign SrcB          = ex_reg.alusrc  ? ex_reg.imm : fwd_val[1];
  assign ex_store_data = fwd_val[1];
  assign Operation     = ex_reg.alu_op;
  assign ex_pc         = ex_reg.pc;
  assign ex_rd         = ex_reg.rd;
  assign ex_valid      = ex_reg.valid;
  assign ex_reg_write  = ex_reg.reg_write;
  assign ex_mem_read   = ex_reg.mem_read;
  assign ex_mem_write  = ex_reg.mem_write;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-operand preparation; sits directly upstream of the ALU.
- Latches decoded instruction fields from ID and resolves EX/MEM and MEM/WB forwarding.
- Selects immediate/PC operands and drives SrcA, SrcB and Operation straight into the ALU.
- Detects load-use hazards and inserts bubbles.

Parameters:
DATA_WIDTH, 32, datapath width
OPCODE_LENGTH, 4, ALU operation code width
REG_ADDR_W, 5, register index width

Ports:
clk  in  1  clock
reset  in  1  reset; synchronous, active-high
id_valid  in  1  ID holds a real instruction
id_pc  in  DATA_WIDTH  instruction PC
id_rs1_data, id_rs2_data  in  DATA_WIDTH  register-file read data
id_imm  in  DATA_WIDTH  sign-extended immediate
id_rs1, id_rs2, id_rd  in  REG_ADDR_W  register indices
id_alu_op  in  OPCODE_LENGTH  ALU operation code
id_alusrc  in  1  1: SrcB = immediate
id_asrc_pc  in  1  1: SrcA = PC (AUIPC/JAL)
id_reg_write, id_mem_read, id_mem_write  in  1  control bits
stall  in  1  freeze EX (downstream memory wait)
flush  in  1  kill EX contents (branch taken)
exm_reg_write  in  1  EX/MEM writes a register
exm_rd  in  REG_ADDR_W  EX/MEM destination
exm_result  in  DATA_WIDTH  EX/MEM ALU result
mwb_reg_write  in  1  MEM/WB writes a register
mwb_rd  in  REG_ADDR_W  MEM/WB destination
mwb_result  in  DATA_WIDTH  MEM/WB writeback value
SrcA, SrcB  out  DATA_WIDTH  ALU operands
Operation  out  OPCODE_LENGTH  ALU operation code
ex_store_data  out  DATA_WIDTH  forwarded rs2 value for stores
ex_pc  out  DATA_WIDTH  registered PC
ex_rd  out  REG_ADDR_W  registered destination
ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered valid and control bits
load_use_stall  out  1  ID/IF must hold this cycle

Behaviour:
- All state updates on rising clk. Priority: reset > flush > stall > load_use_stall > normal capture.
- Reset:
  - All registers clear to 0, so ex_valid=0, all controls=0, ex_rd=0, Operation=4'b0000.
  - SrcA, SrcB and ex_store_data then evaluate to 0.
  - Reset asserted mid-stall or mid-hazard still clears everything.
- flush=1: next state is a bubble (valid, reg_write, mem_read, mem_write, rd, Operation all 0; data fields don't-care). This applies even if stall=1.
- stall=1 (and no flush): every register holds its value.
  - Forwarding keeps re-evaluating combinationally against the current EX/MEM and MEM/WB inputs.
- load_use_stall (combinational):
  - Equals ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2) & id_valid.
  - When 1 (and no flush/stall), EX loads a bubble; ID is expected to hold and re-present the same instruction next cycle.
- Normal capture: all id_* fields register into EX; ex_valid=id_valid. Latency ID→ALU inputs is one cycle.
- Forwarding (combinational, per rs1 and rs2 independently):
  - Source index 0 is never forwarded.
  - EX/MEM match (exm_reg_write & exm_rd==rs) has priority over MEM/WB match (mwb_reg_write & mwb_rd==rs).
  - Otherwise the registered register-file data is used.
- Operand select:
  - SrcA = registered asrc_pc ? ex_pc : fwd_rs1.
  - SrcB = registered alusrc ? imm : fwd_rs2.
  - ex_store_data = fwd_rs2 always.
- Operation is the registered alu_op, passed through unchanged. No width changes anywhere.
- Simultaneous flush and load_use_stall: flush wins; load_use_stall output is still driven from the current state.

Decomposition:
- Shared package (riscv_pkg) holds:
  - ALU op constants: ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_XOR=0011, ALU_SUB=0110, ALU_SLL=0111, ALU_SRL=1000, ALU_SLT=1001, ALU_SLTU=1010, ALU_SRA=1011, ALU_BGE=1100, ALU_BGEU=1101.
  - Forward-select enum {FWD_RF, FWD_EXM, FWD_MWB}.
  - A packed id_ex_t struct for the register contents.
- One sub-module: ex_forward_unit. It is combinational, instantiated twice (rs1 and rs2), and returns the select plus the forwarded value.

Test Plan:
- Reset held 2 cycles with id_valid=1 → ex_valid=0, Operation=0000, SrcA=SrcB=0, load_use_stall=0.
- ADD, rs1=x1 (rf 5), rs2=x2 (rf 7), no forwarding → next cycle SrcA=5, SrcB=7, Operation=0010, ex_valid=1.
- In EX: rs1=x3, exm_rd=3 (exm_result=0x10), mwb_rd=3 (mwb_result=0x20) → SrcA=0x10. Drop exm_reg_write → SrcA=0x20. Set rs1=x0 with exm_rd=0 → SrcA=registered rf data (0).
- EX holds LW rd=x4; ID presents rs2=x4 → load_use_stall=1; next cycle ex_valid=0, ex_reg_write=0, load_use_stall=0.
- stall=1 for 3 cycles with changing id_* → EX fields constant. Then flush=1 together with stall=1 → ex_valid=0 next cycle.
- Immediate and PC operands: id_alusrc=1, id_imm=0xFFFFFFFC, id_asrc_pc=1, id_pc=0x100 → SrcA=0x100, SrcB=0xFFFFFFFC, ex_store_data=forwarded rs2.
